uart_rx_fifo: RTL and testbench

- 8N1 UART receiver with a small first-word-fall-through (FWFT) FIFO; the receive-side counterpart of the SoC's UART emitter.
- Sits on the ftdi_rxd pin and presents received bytes to the memory-mapped IO page through a valid/ready handshake.
- Reports framing errors and overruns through sticky flags, which the CPU reads via the UART control register.

---
 rtl/uart_rx_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined)
//             feeding a first-word-fall-through FIFO with a valid/ready pop
//             port, plus sticky framing / overrun (/ parity) error flags.
//  Macro    : UART_RX_PARITY_EN adds a parity bit and the o_parity_err port.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  input  logic       i_err_clr
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_parity_err
`endif
);

  localparam int c_DIV  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int c_HALF = c_DIV / 2;
  localparam int c_CW   = $clog2(c_DIV);
  localparam int c_AW   = $clog2(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_DIV - 1);
  localparam logic [c_CW-1:0] c_CNT_HALF = c_CW'(c_HALF);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  logic            r_sync1, r_sync2;
  logic            w_rx_s;
  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shreg;
  logic            w_cnt_last, w_stop_done, w_par_ok, w_push, w_frame_set;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_AW:0]   r_wr_ptr, r_rd_ptr;
  logic [c_AW:0]   w_wr_ptr_n, w_rd_ptr_n, w_level_n;
  logic            w_full, w_pop, w_wr_en, w_ovr_set;
  logic [7:0]      w_head_n;
  logic            r_valid, r_frame_err, r_overrun;
  logic [7:0]      r_data;

  assign w_rx_s      = r_sync2;
  assign w_cnt_last  = (r_cnt == c_CNT_LAST);
  assign w_stop_done = (r_state == S_STOP) && w_cnt_last;
  assign w_frame_set = w_stop_done && !w_rx_s;
  assign w_push      = w_stop_done && w_rx_s && w_par_ok;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad, r_parity_err, w_par_set;
  assign w_par_set    = (r_state == S_PARITY) && w_cnt_last && ((^r_shreg) ^ w_rx_s);
  assign w_par_ok     = !r_par_bad;
  assign o_parity_err = r_parity_err;

  // Sticky parity flag; a new error outranks a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (i_rst)               r_parity_err <= 1'b0;
    else if (w_par_set)      r_parity_err <= 1'b1;
    else if (i_err_clr)      r_parity_err <= 1'b0;
  end
`else
  assign w_par_ok = 1'b1;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM: start validated at mid-bit, then one sample per bit period.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == c_CNT_HALF) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        S_DATA: begin
          if (w_cnt_last) begin
            r_cnt          <= '0;
            r_shreg[r_idx] <= w_rx_s;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_cnt_last) begin
            r_cnt     <= '0;
            r_par_bad <= w_par_set;
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_state <= w_rx_s ? S_IDLE : S_WAIT_IDLE;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        S_WAIT_IDLE: begin
          r_cnt <= '0;
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping: a pop on the same edge frees the slot a full push needs.
  assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_pop      = r_valid && i_ready;
  assign w_wr_en    = w_push && (!w_full || w_pop);
  assign w_ovr_set  = w_push && w_full && !w_pop;
  assign w_rd_ptr_n = r_rd_ptr + (c_AW+1)'(w_pop);
  assign w_wr_ptr_n = r_wr_ptr + (c_AW+1)'(w_wr_en);
  assign w_level_n  = w_wr_ptr_n - w_rd_ptr_n;
  // Next head: bypass the incoming byte when it lands in the head slot.
  assign w_head_n   = (w_wr_en && (r_wr_ptr[c_AW-1:0] == w_rd_ptr_n[c_AW-1:0]))
                      ? r_shreg : r_mem[w_rd_ptr_n[c_AW-1:0]];

  // Storage array; contents are meaningless while the pointers say empty.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[c_AW-1:0]] <= r_shreg;
  end

  // Pointers plus registered head/valid so the consumer sees a stable byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
      r_data   <= 8'h00;
    end else begin
      r_wr_ptr <= w_wr_ptr_n;
      r_rd_ptr <= w_rd_ptr_n;
      r_valid  <= (w_level_n != '0);
      if (w_level_n != '0) r_data <= w_head_n;
    end
  end

  // Sticky framing/overrun flags; a new error outranks a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_frame_set)    r_frame_err <= 1'b1;
      else if (i_err_clr) r_frame_err <= 1'b0;
      if (w_ovr_set)      r_overrun   <= 1'b1;
      else if (i_err_clr) r_overrun   <= 1'b0;
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Purpose  : Self-checking bench for uart_rx_fifo (DIV = 16, depth 4),
//             directed scenarios followed by a randomized frame/pop phase
//             checked against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;
  localparam int DIV   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Stop-bit sample edge, counted in clocks from the start-bit edge:
  // 2 sync stages + 1 idle detect + HALF + 1 reaches mid start bit,
  // then one DIV per following bit up to the stop bit.
  localparam int RISE_K = 2 + 1 + DIV/2 + 1 + DIV*(NBITS-1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic       err_clr = 1'b0;
  wire  [7:0] o_data;
  wire        o_valid, o_frame_err, o_overrun;
`ifdef UART_RX_PARITY_EN
  wire        o_parity_err;
`endif

  uart_rx_fifo #(.CLK_FREQ_HZ(16), .BAUD_RATE(1), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx), .o_data(o_data), .o_valid(o_valid),
    .i_ready(ready), .o_frame_err(o_frame_err), .o_overrun(o_overrun), .i_err_clr(err_clr)
`ifdef UART_RX_PARITY_EN
    , .o_parity_err(o_parity_err)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] q[$];
  logic       m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame; samples happen on each negedge before driving.
  task automatic send_frame(input logic [7:0] b, input logic stopb, input logic parb,
                            input int pop_at, input int rst_at,
                            output int rise_k, output logic [7:0] popped);
    logic [10:0] fr;
    logic        prev_v;
`ifdef UART_RX_PARITY_EN
    fr = {1'b1, stopb, parb, b, 1'b0};
`else
    fr = {parb, stopb, b, 1'b0};
`endif
    rise_k = -1;
    popped = 8'h00;
    prev_v = 1'b0;
    for (int k = 0; k < NBITS*DIV; k++) begin
      @(negedge clk);
      if (k > 0 && !prev_v && o_valid && rise_k < 0) rise_k = k;
      prev_v = o_valid;
      if (k == pop_at) popped = o_data;
      ready = (k == pop_at);
      rst   = (k == rst_at);
      rx    = fr[k/DIV];
    end
    ready = 1'b0;
    rst   = 1'b0;
  endtask

  // Frame plus reference-model update (pop precedes push on the same edge).
  task automatic frame(input string tag, input logic [7:0] b, input logic stopb,
                       input logic par_good, input int pop_at, output int rise_k);
    logic [7:0] popped;
    logic       parb;
    parb = par_good ? ^b : ~^b;
    send_frame(b, stopb, parb, pop_at, -1, rise_k, popped);
    if (pop_at >= 0 && q.size() > 0) begin
      chk({tag, "_coinc_pop"}, popped, q[0]);
      void'(q.pop_front());
    end
`ifdef UART_RX_PARITY_EN
    if (!par_good) m_perr = 1'b1;
`else
    par_good = 1'b1;
`endif
    if (!stopb) m_ferr = 1'b1;
    else if (par_good) begin
      if (q.size() < DEPTH) q.push_back(b);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, o_valid, (q.size() != 0));
    if (q.size() != 0) chk({tag, "_data"}, o_data, q[0]);
    chk({tag, "_ovr"}, o_overrun, m_ovr);
    chk({tag, "_ferr"}, o_frame_err, m_ferr);
`ifdef UART_RX_PARITY_EN
    chk({tag, "_perr"}, o_parity_err, m_perr);
`endif
  endtask

  task automatic pop(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, o_valid, (q.size() != 0));
    if (q.size() != 0) chk({tag, "_data"}, o_data, q[0]);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clear_errs();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         rk;
    logic [7:0] dummy;
    logic [7:0] rb;
    logic       rs;

    // Reset state
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_data", o_data, 8'h00);
    chk("rst_ferr", o_frame_err, 1'b0);
    chk("rst_ovr", o_overrun, 1'b0);
    idle(4);

    // Single byte with exact push latency
    frame("a5", 8'hA5, 1'b1, 1'b1, -1, rk);
    chk("a5_latency", rk, RISE_K);
    check_model("a5");
    chk("a5_lit", o_data, 8'hA5);
    pop("a5_pop");
    check_model("a5_empty");

    // Back-to-back with backpressure: fifth byte overruns
    for (int i = 1; i <= 5; i++) frame("b2b", 8'(i), 1'b1, 1'b1, -1, rk);
    check_model("b2b");
    chk("b2b_ovr_lit", o_overrun, 1'b1);
    for (int i = 0; i < 5; i++) pop("b2b_pop");
    clear_errs();
    check_model("b2b_clr");

    // Full boundary: pop coincides with the push of the fifth byte
    for (int i = 1; i <= 4; i++) frame("fb", 8'(8'h10 + i), 1'b1, 1'b1, -1, rk);
    frame("fb5", 8'h15, 1'b1, 1'b1, RISE_K - 1, rk);
    check_model("fb5");
    chk("fb5_ovr_lit", o_overrun, 1'b0);
    for (int i = 0; i < 5; i++) pop("fb_pop");

    // Glitch on idle line
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    check_model("glitch");

    // Framing error followed by a line break
    frame("ferr", 8'h3C, 1'b0, 1'b1, -1, rk);
    repeat (40) @(negedge clk);
    idle(6);
    check_model("brk");
    chk("brk_ferr_lit", o_frame_err, 1'b1);
    frame("7e", 8'h7E, 1'b1, 1'b1, -1, rk);
    idle(2);
    check_model("7e");
    pop("7e_pop");
    clear_errs();
    check_model("ferr_clr");

    // Reset during data bit 4 of 0xFF, with a byte already queued
    frame("pre", 8'h9B, 1'b1, 1'b1, -1, rk);
    send_frame(8'hFF, 1'b1, 1'b0, -1, DIV*5 + 5, rk, dummy);
    q.delete();
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    idle(4);
    check_model("midrst");
    chk("midrst_data", o_data, 8'h00);
    frame("55", 8'h55, 1'b1, 1'b1, -1, rk);
    check_model("55");
    pop("55_pop");

`ifdef UART_RX_PARITY_EN
    // Parity mismatch then a good frame; flag sticks until cleared
    frame("pbad", 8'h03, 1'b1, 1'b0, -1, rk);
    check_model("pbad");
    frame("pgood", 8'h03, 1'b1, 1'b1, -1, rk);
    check_model("pgood");
    pop("pgood_pop");
    clear_errs();
    check_model("pclr");
`endif

    // Randomized frames and pops against the model
    for (int t = 0; t < 14; t++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      frame("rnd", rb, rs, ($urandom_range(0, 4) != 0), -1, rk);
`else
      frame("rnd", rb, rs, 1'b1, -1, rk);
`endif
      idle(4);
      check_model("rnd");
      repeat ($urandom_range(0, 3)) pop("rnd_pop");
      if ($urandom_range(0, 3) == 0) clear_errs();
    end
    while (q.size() != 0) pop("drain");
    check_model("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
